// File: rtl/multi_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_interval_timer
// Brief    : NUM_CH prescaled down-counter interval timers behind an Avalon-MM slave.
// Revision : 1.0  initial release
// ============================================================================
module multi_interval_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999999,
  parameter int ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam logic [CNT_W-1:0] c_RST_PERIOD = CNT_W'(RESET_PERIOD);

  logic [31:0]       w_addr_ext;
  logic [29:0]       w_ch;
  logic [1:0]        w_reg;
  logic              w_wr;
  logic [31:0]       w_rd_ch [NUM_CH];
  logic [31:0]       w_rd_data;
  logic [NUM_CH-1:0] w_irq_vec_d;
  logic              w_unused_wdata;

  logic [31:0]       readdata_q;
  logic [NUM_CH-1:0] irq_vec_q;
  logic              irq_q;

  // Zero-extending the address lets a single-channel build share the decode.
  assign w_addr_ext     = 32'(address);
  assign w_ch           = w_addr_ext[31:2];
  assign w_reg          = w_addr_ext[1:0];
  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             w_sel, w_wr_status, w_wr_ctrl, w_wr_period, w_wr_snap;
    logic             w_tick, w_event;
    logic [CNT_W-1:0] period_q, period_d, count_q, count_d, snap_q, snap_d;
    logic [PRE_W-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
    logic             ito_q, ito_d, cont_q, cont_d, start_q, start_d;
    logic             stop_q, stop_d, run_q, run_d, to_q, to_d;

    assign w_sel       = w_wr && (w_ch == 30'(i));
    assign w_wr_status = w_sel && (w_reg == 2'd0);
    assign w_wr_ctrl   = w_sel && (w_reg == 2'd1);
    assign w_wr_period = w_sel && (w_reg == 2'd2);
    assign w_wr_snap   = w_sel && (w_reg == 2'd3);

    assign w_tick  = run_q && (pre_cnt_q == '0);
    // A PERIOD load on a tick cycle swallows that tick's timeout.
    assign w_event = w_tick && (count_q == '0) && !w_wr_period;

    always_comb begin
      period_d   = period_q;
      count_d    = count_q;
      snap_d     = snap_q;
      prescale_d = prescale_q;
      pre_cnt_d  = pre_cnt_q;
      ito_d      = ito_q;
      cont_d     = cont_q;
      start_d    = start_q;
      stop_d     = stop_q;
      run_d      = run_q;
      to_d       = to_q;

      if (w_wr_ctrl) begin
        ito_d      = writedata[0];
        cont_d     = writedata[1];
        start_d    = writedata[2];
        stop_d     = writedata[3];
        prescale_d = writedata[8 +: PRE_W];
      end

      if (w_wr_period) begin
        period_d = writedata[CNT_W-1:0];
        count_d  = writedata[CNT_W-1:0];
      end else if (w_tick) begin
        count_d = (count_q == '0) ? period_q : count_q - CNT_W'(1);
      end

      if (w_wr_period || !run_q || w_tick) pre_cnt_d = prescale_d;
      else                                 pre_cnt_d = pre_cnt_q - PRE_W'(1);

      if (w_event && !cont_q) run_d = 1'b0;
      if (w_wr_ctrl) begin
        if (writedata[3])      run_d = 1'b0;
        else if (writedata[2]) run_d = 1'b1;
      end
      if (w_wr_period) run_d = 1'b0;

      if (w_wr_status) to_d = 1'b0;
      if (w_event)     to_d = 1'b1;

      if (w_wr_snap) snap_d = count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        period_q   <= c_RST_PERIOD;
        count_q    <= c_RST_PERIOD;
        snap_q     <= '0;
        prescale_q <= '0;
        pre_cnt_q  <= '0;
        ito_q      <= 1'b0;
        cont_q     <= 1'b0;
        start_q    <= 1'b0;
        stop_q     <= 1'b0;
        run_q      <= 1'b0;
        to_q       <= 1'b0;
      end else begin
        period_q   <= period_d;
        count_q    <= count_d;
        snap_q     <= snap_d;
        prescale_q <= prescale_d;
        pre_cnt_q  <= pre_cnt_d;
        ito_q      <= ito_d;
        cont_q     <= cont_d;
        start_q    <= start_d;
        stop_q     <= stop_d;
        run_q      <= run_d;
        to_q       <= to_d;
      end
    end

    assign w_irq_vec_d[i] = to_d & ito_d;

    always_comb begin
      case (w_reg)
        2'd0:    w_rd_ch[i] = {30'd0, run_q, to_q};
        2'd1:    w_rd_ch[i] = 32'({prescale_q, 4'b0000, stop_q, start_q, cont_q, ito_q});
        2'd2:    w_rd_ch[i] = 32'(period_q);
        default: w_rd_ch[i] = 32'(snap_q);
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == 30'(i)) w_rd_data = w_rd_ch[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq_vec_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= w_rd_data;
      irq_vec_q  <= w_irq_vec_d;
      irq_q      <= |w_irq_vec_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_vec  = irq_vec_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_interval_timer
// Brief    : Directed self-checking bench for a 3-channel multi_interval_timer.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_interval_timer;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [2:0]  irq_vec;
  logic        irq;

  int checks = 0;
  int errors = 0;

  multi_interval_timer #(
    .NUM_CH      (3),
    .CNT_W       (32),
    .PRE_W       (8),
    .RESET_PERIOD(49999999)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq_vec   (irq_vec),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_vec", 32'(irq_vec), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("rst_ch0_period", 4'd2, 32'h02FAF07F);
    rd_chk("rst_ch0_status", 4'd0, 32'h0);
    check("rst_irq_after", 32'(irq), 32'h0);

    // Continuous, no prescale: ch1 PERIOD=4 -> timeout every 5 clocks
    wr(4'd6, 32'd4);
    wr(4'd5, 32'h7);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("cont_irq_k%0d", k), 32'(irq), 32'(k == 5));
    end
    check("cont_irq_vec", 32'(irq_vec), 32'b010);
    wr(4'd4, 32'h0);
    check("cont_clr_irq", 32'(irq), 32'h0);
    for (int k = 7; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("cont_re_irq_k%0d", k), 32'(irq), 32'(k == 10));
    end
    check("cont_re_irq_vec", 32'(irq_vec), 32'b010);
    rd_chk("cont_status", 4'd4, 32'h3);
    wr(4'd5, 32'h8);
    wr(4'd4, 32'h0);

    // One-shot with prescale 3: ch2 PERIOD=2 -> single timeout 12 clocks later
    wr(4'd10, 32'd2);
    wr(4'd9, 32'h305);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("os_irq_k%0d", k), 32'(irq), 32'(k == 12));
    end
    check("os_irq_vec", 32'(irq_vec), 32'b100);
    rd_chk("os_status", 4'd8, 32'h1);
    wr(4'd11, 32'h0);
    rd_chk("os_count", 4'd11, 32'd2);
    wr(4'd8, 32'h0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("os_quiet_k%0d", k), 32'(irq), 32'h0);
    end

    // SNAP and STOP on ch0
    wr(4'd2, 32'd100);
    wr(4'd1, 32'h4);
    repeat (9) @(posedge clk);
    wr(4'd3, 32'h0);
    wr(4'd1, 32'h8);
    rd_chk("snap_91", 4'd3, 32'd91);
    wr(4'd3, 32'h0);
    repeat (5) @(posedge clk);
    wr(4'd3, 32'h0);
    rd_chk("snap_frozen", 4'd3, 32'd89);
    rd_chk("snap_status", 4'd0, 32'h0);

    // STATUS clear on the timeout edge: set wins
    wr(4'd6, 32'd3);
    wr(4'd5, 32'h6);
    repeat (3) @(posedge clk);
    wr(4'd4, 32'h0);
    rd_chk("coll_status_set", 4'd4, 32'h3);
    wr(4'd5, 32'h8);
    wr(4'd4, 32'h0);

    // START and STOP together: STOP wins
    wr(4'd9, 32'hC);
    rd_chk("coll_startstop_run", 4'd8, 32'h0);
    rd_chk("coll_startstop_ctrl", 4'd9, 32'hC);

    // PERIOD write on a tick edge with count 0: load wins, no timeout
    wr(4'd10, 32'd0);
    wr(4'd9, 32'h106);
    @(posedge clk);
    wr(4'd10, 32'd7);
    rd_chk("coll_period_status", 4'd8, 32'h0);
    wr(4'd11, 32'h0);
    rd_chk("coll_period_count", 4'd11, 32'd7);

    // Channel 3 does not exist
    wr(4'd14, 32'h55);
    wr(4'd13, 32'h107);
    wr(4'd15, 32'h0);
    wr(4'd12, 32'h0);
    for (int r = 12; r <= 15; r++) begin
      rd_chk($sformatf("iso_rd_%0d", r), 4'(r), 32'h0);
    end
    rd_chk("iso_ch0_period", 4'd2, 32'd100);
    rd_chk("iso_ch1_period", 4'd6, 32'd3);
    rd_chk("iso_ch2_period", 4'd10, 32'd7);
    rd_chk("iso_ch0_ctrl", 4'd1, 32'h8);
    rd_chk("iso_ch1_ctrl", 4'd5, 32'h8);
    rd_chk("iso_ch2_ctrl", 4'd9, 32'h106);
    rd_chk("iso_ch0_status", 4'd0, 32'h0);
    rd_chk("iso_ch1_status", 4'd4, 32'h0);
    rd_chk("iso_ch2_status", 4'd8, 32'h0);
    check("iso_irq", 32'(irq), 32'h0);

    // Simultaneous ch0/ch2 timeouts and irq as OR of irq_vec
    wr(4'd2, 32'd3);
    wr(4'd10, 32'd2);
    wr(4'd1, 32'h7);
    wr(4'd9, 32'h7);
    check("sim_irq_n1", 32'(irq), 32'h0);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sim_irq_vec_k%0d", k), 32'(irq_vec), (k == 4) ? 32'b101 : 32'b000);
      check($sformatf("sim_irq_k%0d", k), 32'(irq), 32'(k == 4));
    end
    wr(4'd0, 32'h0);
    check("sim_clr0_irq_vec", 32'(irq_vec), 32'b100);
    check("sim_clr0_irq", 32'(irq), 32'h1);
    wr(4'd8, 32'h0);
    check("sim_clr2_irq_vec", 32'(irq_vec), 32'b000);
    check("sim_clr2_irq", 32'(irq), 32'h0);

    // Asynchronous reset mid-count
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_irq_vec", 32'(irq_vec), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("arst_ch0_period", 4'd2, 32'h02FAF07F);
    rd_chk("arst_ch2_period", 4'd10, 32'h02FAF07F);
    rd_chk("arst_ch0_ctrl", 4'd1, 32'h0);
    rd_chk("arst_ch2_snap", 4'd11, 32'h0);
    check("arst_irq_after", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
